// File: rtl/blc_line_sequencer.sv
// Line-level sequencer for black-level correction: pixel phase decoding, black triplet
// marking, settle/reference handshake and drain of buffered active pixels.
module blc_line_sequencer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HDR         = 1,
    parameter int unsigned BPN_L       = 150,
    parameter int unsigned READ_PIXEL  = 16,
    parameter int unsigned BPN_R       = 150,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned REF_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic black_en,
    output logic active_en,
    output logic trio_last,
    output logic acc_clr,
    output logic ref_start,
    input  logic ref_valid,
    input  logic rd_ready,
    output logic rd_en,
    output logic rd_last,
    output logic busy,
    input  logic err_clr,
    output logic err_overrun,
    output logic err_timeout
);

    localparam int unsigned LINE_LEN = HDR + BPN_L + READ_PIXEL + BPN_R;

    localparam logic [15:0] L_BLK_L0   = 16'(HDR);
    localparam logic [15:0] L_ACT0     = 16'(HDR + BPN_L);
    localparam logic [15:0] L_BLK_R0   = 16'(HDR + BPN_L + READ_PIXEL);
    localparam logic [15:0] L_END      = 16'(LINE_LEN);
    localparam logic [15:0] L_LAST     = 16'(LINE_LEN - 1);
    localparam logic [15:0] L_SET_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] L_TO_LAST  = 16'(REF_TIMEOUT - 1);
    localparam logic [15:0] L_RD_LAST  = 16'(READ_PIXEL - 1);

    if (DATA_WIDTH == 0 || READ_PIXEL == 0 || SETTLE_CYC == 0 || REF_TIMEOUT == 0)
    begin : g_param_check
        $error("blc_line_sequencer: zero-sized parameter");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SETTLE,
        S_WAIT_REF,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [15:0] r_pix_cnt;
    logic [15:0] r_rd_cnt;
    logic [15:0] r_tmr;
    logic [1:0]  r_grp_cnt;
    logic        r_ref_start;
    logic        r_busy;
    logic        r_err_ovr;
    logic        r_err_to;

    logic        w_capturing;
    logic        w_cap;
    logic [15:0] w_p;
    logic        w_blk;
    logic        w_act;
    logic        w_region_start;
    logic [1:0]  w_grp;
    logic        w_ovr_set;
    logic        w_to_set;

    always_comb begin
        w_capturing    = (r_state == S_IDLE) || (r_state == S_CAPTURE);
        w_cap          = i_valid && !rst && w_capturing;
        // The IDLE pixel is always p=0; pix_cnt only holds the index once capturing.
        w_p            = (r_state == S_IDLE) ? '0 : r_pix_cnt;
        w_blk          = ((w_p >= L_BLK_L0) && (w_p < L_ACT0)) ||
                         ((w_p >= L_BLK_R0) && (w_p < L_END));
        w_act          = (w_p >= L_ACT0) && (w_p < L_BLK_R0);
        w_region_start = (w_p == L_BLK_L0) || (w_p == L_BLK_R0);
        w_grp          = w_region_start ? '0 : r_grp_cnt;
        black_en       = w_cap && w_blk;
        active_en      = w_cap && w_act;
        trio_last      = black_en && (w_grp == 2'd2);
        acc_clr        = w_cap && (r_state == S_IDLE);
        rd_en          = !rst && (r_state == S_DRAIN) && rd_ready;
        rd_last        = rd_en && (r_rd_cnt == L_RD_LAST);
        w_ovr_set      = i_valid && !w_capturing;
        w_to_set       = (r_state == S_WAIT_REF) && !ref_valid && (r_tmr == L_TO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_tmr       <= '0;
            r_grp_cnt   <= '0;
            r_ref_start <= 1'b0;
            r_busy      <= 1'b0;
            r_err_ovr   <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_ref_start <= 1'b0;
            if (black_en)
                r_grp_cnt <= (w_grp == 2'd2) ? '0 : w_grp + 2'd1;

            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_busy <= 1'b1;
                        if (L_LAST == '0) begin
                            r_state   <= S_SETTLE;
                            r_pix_cnt <= '0;
                            r_tmr     <= '0;
                        end else begin
                            r_state   <= S_CAPTURE;
                            r_pix_cnt <= 16'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (i_valid) begin
                        if (r_pix_cnt == L_LAST) begin
                            r_state   <= S_SETTLE;
                            r_pix_cnt <= '0;
                            r_tmr     <= '0;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 16'd1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_tmr == L_SET_LAST) begin
                        r_ref_start <= 1'b1;
                        r_state     <= S_WAIT_REF;
                        r_tmr       <= '0;
                    end else begin
                        r_tmr <= r_tmr + 16'd1;
                    end
                end
                S_WAIT_REF: begin
                    if (ref_valid) begin
                        r_state  <= S_DRAIN;
                        r_rd_cnt <= '0;
                    end else if (w_to_set) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= r_tmr + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (rd_en) begin
                        if (rd_last) begin
                            r_state  <= S_IDLE;
                            r_busy   <= 1'b0;
                            r_rd_cnt <= '0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Sticky flags: a new event wins over a simultaneous clear.
            if (w_ovr_set)    r_err_ovr <= 1'b1;
            else if (err_clr) r_err_ovr <= 1'b0;
            if (w_to_set)     r_err_to  <= 1'b1;
            else if (err_clr) r_err_to  <= 1'b0;
        end
    end

    assign ref_start   = r_ref_start;
    assign busy        = r_busy;
    assign err_overrun = r_err_ovr;
    assign err_timeout = r_err_to;

endmodule

// File: tb/tb_blc_line_sequencer.sv
// Scoreboard bench for blc_line_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_blc_line_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_valid = 1'b0;
    logic ref_valid = 1'b0;
    logic rd_ready = 1'b0;
    logic err_clr = 1'b0;
    logic black_en, active_en, trio_last, acc_clr, ref_start;
    logic rd_en, rd_last, busy, err_overrun, err_timeout;

    blc_line_sequencer #(
        .DATA_WIDTH(8), .HDR(1), .BPN_L(150), .READ_PIXEL(16),
        .BPN_R(150), .SETTLE_CYC(4), .REF_TIMEOUT(1023)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid),
        .black_en(black_en), .active_en(active_en), .trio_last(trio_last),
        .acc_clr(acc_clr), .ref_start(ref_start), .ref_valid(ref_valid),
        .rd_ready(rd_ready), .rd_en(rd_en), .rd_last(rd_last), .busy(busy),
        .err_clr(err_clr), .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_trio  = 0;
    bit   exp_ov  = 1'b0;
    bit   exp_to  = 1'b0;

    // Vector order: acc_clr black_en active_en trio_last ref_start rd_en rd_last busy err_overrun err_timeout
    initial begin
        exp_t       e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {acc_clr, black_en, active_en, trio_last, ref_start,
                       rd_en, rd_last, busy, err_overrun, err_timeout};
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b want %b", e.name, act, e.exp);
                end
                if (trio_last === 1'b1) n_trio++;
            end
        end
    end

    task automatic step(input string name, input bit r, iv, rv, rr, ec, ovr,
                        input logic [6:0] e7, input bit eb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; i_valid = iv; ref_valid = rv; rd_ready = rr; err_clr = ec;
        if (r) begin exp_ov = 1'b0; exp_to = 1'b0; end
        e.name = name;
        e.exp  = {e7, eb, exp_ov, exp_to};
        q.push_back(e);
        if (!r) begin
            if (ec)  begin exp_ov = 1'b0; exp_to = 1'b0; end
            if (ovr) exp_ov = 1'b1;
        end
    endtask

    // Hand-derived phase map for the default 1/150/16/150 line.
    function automatic logic [6:0] pix_exp(input int p);
        bit a, b, c, t;
        a = (p == 0);
        b = (p >= 1 && p <= 150) || (p >= 167 && p <= 316);
        c = (p >= 151 && p <= 166);
        t = (p >= 3 && p <= 150 && p % 3 == 0) || (p >= 169 && p <= 316 && (p - 169) % 3 == 0);
        return {a, b, c, t, 3'b000};
    endfunction

    task automatic line_pixels(input string tag, input int n);
        for (int p = 0; p < n; p++)
            step($sformatf("%s p%0d", tag, p), 0, 1, 0, 0, 0, 0, pix_exp(p), p != 0);
    endtask

    task automatic settle(input string tag);
        for (int k = 0; k < 4; k++)
            step($sformatf("%s settle%0d", tag, k), 0, 0, 0, 0, 0, 0, 7'b0, 1);
    endtask

    task automatic wait_ref(input string tag, input int n, input int iv_at);
        for (int k = 0; k < n; k++)
            step($sformatf("%s wait%0d", tag, k), 0, k == iv_at, 0, 0, 0, k == iv_at,
                 {4'b0, k == 0, 2'b00}, 1);
    endtask

    task automatic refv(input string tag);
        step({tag, " refv"}, 0, 0, 1, 1, 0, 0, 7'b0, 1);
    endtask

    task automatic drain(input string tag, input int per, input int iv_at);
        int pops;
        bit rr, hit;
        pops = 0;
        for (int c = 0; c < 200 && pops < 16; c++) begin
            rr  = (c % per) == 0;
            hit = (c == iv_at);
            step($sformatf("%s drain%0d", tag, c), 0, hit, 0, rr, hit, hit,
                 {5'b0, rr, rr && pops == 15}, 1);
            if (rr) pops++;
        end
        step({tag, " post-drain"}, 0, 0, 0, 1, 0, 0, 7'b0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++)
            step("reset", 1, 1, 0, 0, 0, 0, 7'b0, 0);

        n_trio = 0;
        line_pixels("t1", 317);
        settle("t2");
        n_tests++;
        if (n_trio != 100) begin
            n_fail++;
            $display("FAIL t1 trio count: got %0d want 100", n_trio);
        end
        wait_ref("t2", 10, -1);
        refv("t2");
        drain("t2", 1, -1);

        line_pixels("t3", 317);
        settle("t3");
        wait_ref("t3", 2, -1);
        refv("t3");
        drain("t3", 3, -1);

        line_pixels("t4a", 317);
        settle("t4a");
        wait_ref("t4a", 1023, -1);
        exp_to = 1'b1;
        step("t4 idle0", 0, 0, 1, 0, 0, 0, 7'b0, 0);
        step("t4 idle1", 0, 0, 1, 0, 0, 0, 7'b0, 0);
        line_pixels("t4b", 317);
        settle("t4b");
        wait_ref("t4b", 3, -1);
        refv("t4b");
        drain("t4b", 1, -1);
        step("t4 clr", 0, 0, 0, 0, 1, 0, 7'b0, 0);
        step("t4 cleared", 0, 0, 0, 0, 0, 0, 7'b0, 0);

        line_pixels("t5", 317);
        settle("t5");
        wait_ref("t5", 5, 1);
        refv("t5");
        drain("t5", 1, 2);
        step("t5 sticky", 0, 0, 0, 0, 1, 0, 7'b0, 0);
        step("t5 cleared", 0, 0, 0, 0, 0, 0, 7'b0, 0);

        line_pixels("t6a", 100);
        step("t6 rst0", 1, 1, 0, 0, 0, 0, 7'b0, 0);
        step("t6 rst1", 1, 1, 0, 0, 0, 0, 7'b0, 0);
        line_pixels("t6b", 5);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
